// File: rtl/wptr_full_prog.sv
// Write-side pointer and flag generator for the gray-pointer FIFO family.
// Keeps a binary write pointer and publishes its gray form to the read domain.
// Computes the exact fill level from the synchronised read pointer.
// Derives full, programmable almost-full and sticky overflow from that level.
module wptr_full_prog #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_RESET = (1 << ADDRSIZE) - 1
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                thresh_ld,
  input  logic [ADDRSIZE:0]   thresh_in,
  input  logic                wovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wfull,
  output logic                awfull,
  output logic                wovf,
  output logic [ADDRSIZE:0]   afull_thresh
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
  // An out-of-range reset threshold is clamped the same way a run-time load is.
  localparam int THR_RST_I = (AFULL_RESET > (1 << ADDRSIZE)) ? (1 << ADDRSIZE) : AFULL_RESET;
  localparam logic [PW-1:0] THR_RST = PW'(THR_RST_I);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Saturate a requested threshold to the FIFO depth.
  function automatic logic [PW-1:0] clamp_thresh(input logic [PW-1:0] t);
    return (t > DEPTH) ? DEPTH : t;
  endfunction

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_awfull;
  logic          r_wovf;
  logic [PW-1:0] r_thresh;

  logic          w_wen;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_wbinnext;
  logic [PW-1:0] w_wgraynext;
  logic [PW-1:0] w_lvl_next;
  logic          w_ovf_set;

  // A write is only accepted while the registered full flag is low; a dropped
  // write leaves every pointer where it is.
  assign w_wen       = winc & ~r_wfull;
  assign w_rbin      = gray2bin(wq2_rptr);
  assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_wen};
  assign w_wgraynext = bin2gray(w_wbinnext);
  // Modular subtraction stays correct across the pointer wrap thanks to the extra MSB.
  assign w_lvl_next  = w_wbinnext - w_rbin;
  assign w_ovf_set   = winc & r_wfull;

  // Pointer, level and level-derived flags advance together every cycle.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wlevel <= '0;
      r_wfull  <= 1'b0;
      r_awfull <= 1'b0;
    end else begin
      r_wbin   <= w_wbinnext;
      r_wptr   <= w_wgraynext;
      r_wlevel <= w_lvl_next;
      r_wfull  <= (w_lvl_next == DEPTH);
      r_awfull <= (w_lvl_next >= r_thresh);
    end
  end

  // Threshold register; a new value takes part in the compare from the next cycle.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_thresh <= THR_RST;
    end else if (thresh_ld) begin
      r_thresh <= clamp_thresh(thresh_in);
    end
  end

  // Sticky overflow: a blocked write sets it and wins over a same-cycle clear.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_wovf <= 1'b1;
    end else if (wovf_clr) begin
      r_wovf <= 1'b0;
    end
  end

  assign wen          = w_wen;
  assign waddr        = r_wbin[ADDRSIZE-1:0];
  assign wptr         = r_wptr;
  assign wlevel       = r_wlevel;
  assign wfull        = r_wfull;
  assign awfull       = r_awfull;
  assign wovf         = r_wovf;
  assign afull_thresh = r_thresh;

endmodule

// File: doc/wptr_full_prog.md
Name: wptr_full_prog

Overview:
- Parametrised write-side pointer and flag generator for the gray-pointer FIFO family. One generation on from the fixed-threshold write-pointer block.
- Produces the write address and the gray write pointer for the read-domain synchroniser. Also converts the synchronised gray read pointer back to binary.
- Outputs an exact fill level, full, a run-time programmable almost-full flag, a memory write enable, and a sticky overflow flag.
- Sits in the write clock domain between the producer (audio/FFT sample writer) and the dual-port FIFO RAM.

Parameters:
- ADDRSIZE, 4: address width. DEPTH = 2**ADDRSIZE words. Legal range 2..12.
- AFULL_RESET, 2**ADDRSIZE-1: almost-full threshold loaded at reset when thresh_ld has never been pulsed.

Ports:
- wclk  in  1: write clock. All logic is on its rising edge.
- wrst_n  in  1: reset, synchronous, active-low.
- winc  in  1: write request for this cycle.
- wq2_rptr  in  ADDRSIZE+1: gray read pointer, already double-synchronised into wclk.
- thresh_ld  in  1: load thresh_in into the almost-full threshold register.
- thresh_in  in  ADDRSIZE+1: new threshold value, 0..DEPTH.
- wovf_clr  in  1: clear the sticky overflow flag.
- wen  out  1: RAM write enable, combinational = winc & ~wfull.
- waddr  out  ADDRSIZE: RAM write address = wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1: registered gray write pointer.
- wlevel  out  ADDRSIZE+1: registered fill level, 0..DEPTH.
- wfull  out  1: registered full flag.
- awfull  out  1: registered almost-full flag.
- wovf  out  1: sticky overflow flag.
- afull_thresh  out  ADDRSIZE+1: current threshold register value.

Behaviour:
- Reset is synchronous, sampled on the wclk edge while wrst_n=0.
  - Reset values: wbin=0, wptr=0, wlevel=0, wfull=0, awfull=0, wovf=0, afull_thresh=AFULL_RESET.
  - Reset mid-operation discards all pointer state. The read side must be reset in the same window; this block does not coordinate that.
- Read pointer conversion: rbin_s = gray-to-binary of wq2_rptr, combinational.
- Next-state values, all mod 2**(ADDRSIZE+1):
  - wbinnext = wbin + wen
  - wgraynext = (wbinnext>>1) ^ wbinnext
  - lvl_next = wbinnext - rbin_s
- Registered updates each cycle: wbin<=wbinnext; wptr<=wgraynext; wlevel<=lvl_next; wfull<=(lvl_next==DEPTH); awfull<=(lvl_next>=afull_thresh).
- Flag latency:
  - All flags update one cycle after the causing write, with no extra delay. The write that fills the FIFO asserts wfull on the next edge, so a second write is blocked.
  - Read-side frees are seen with the synchroniser delay plus one edge. Flags are therefore pessimistic and never optimistic.
- Level bound: lvl_next never exceeds DEPTH when wq2_rptr is a valid delayed read pointer. A larger value is a protocol violation and needs no defined flags.
- Threshold register:
  - afull_thresh<=thresh_in when thresh_ld=1. The new value is used from the following cycle's compare.
  - Values above DEPTH are clamped to DEPTH on load.
  - Threshold 0 makes awfull=1 from the first cycle after reset.
  - Threshold DEPTH makes awfull equal to wfull.
- Overflow:
  - wovf is set on any cycle with winc=1 and wfull=1.
  - wovf_clr=1 clears it. Set wins if both happen in the same cycle.
  - A dropped write does not move any pointer.
- Wrap-around: wbin wraps from 2**(ADDRSIZE+1)-1 to 0. waddr wraps every DEPTH writes. The MSB and gray encoding give correct full detection across the wrap.
- Gray integrity: wptr changes in at most one bit per clock.

Test Plan (ADDRSIZE=4, DEPTH=16):
1. Reset, then hold wq2_rptr=0 and apply winc=1 for 17 cycles:
   - waddr steps 0..15.
   - wfull=1 on the edge after the 16th write and wlevel=16.
   - The 17th write gives wen=0 and wovf=1.
2. Starting full, drive wq2_rptr to gray(4) = 5'b00110:
   - The next edge gives wlevel=12, wfull=0.
   - With winc=1 the FIFO refills to 16 in 4 writes.
3. Load thresh_in=10 via thresh_ld with rptr=0:
   - awfull=0 while wlevel=9 and becomes 1 when wlevel reaches 10.
   - Load 20: afull_thresh reads 16 (clamped).
4. Run 40 writes with the read pointer trailing by 3 entries:
   - waddr and wptr wrap correctly and wptr changes one bit per cycle.
   - wlevel stays 3, wfull stays 0 across the 31->0 wbin wrap.
5. Assert wovf_clr and a blocked write in the same cycle -> wovf stays 1. wovf_clr alone on the next cycle -> wovf=0.
6. Assert reset mid-stream with wlevel=7 -> on the next edge all outputs are 0 and afull_thresh returns to AFULL_RESET=15.
